// File: rtl/dest_arbiter.sv
// Round-robin packet arbiter merging NUM_PORTS AXI4-Stream sources into one tagged stream.
// Define DEST_ARBITER_REG_OUT_EN to add a full-throughput register slice on the initiator side.
module dest_arbiter #(
   parameter int unsigned NUM_PORTS  = 4,
   parameter int unsigned DATA_WIDTH = 8
) (
   input  logic                            aclk,
   input  logic                            aresetn,
   input  logic [NUM_PORTS-1:0]            target_tvalid,
   output logic [NUM_PORTS-1:0]            target_tready,
   input  logic [NUM_PORTS-1:0]            target_tlast,
   input  logic [NUM_PORTS*DATA_WIDTH-1:0] target_tdata,
   output logic                            initiator_tvalid,
   input  logic                            initiator_tready,
   output logic                            initiator_tlast,
   output logic [DATA_WIDTH-1:0]           initiator_tdata,
   output logic [2:0]                      initiator_tid
);

   localparam int unsigned MaxPorts = 8;

   typedef enum logic [0:0] {StIdle, StBusy} state_e;

   state_e              state_q;
   logic [2:0]          grant_q, grant_d, last_grant_q;
   logic                found;
   logic [2:0]          idx;
   logic [MaxPorts-1:0] vld_ext, last_ext;
   logic [DATA_WIDTH-1:0] data_ext [MaxPorts];
   logic                busy, g_valid, g_last, up_valid, up_ready, fire_last;
   logic [DATA_WIDTH-1:0] g_data;

   // Pad the per-port inputs to 8 entries so the 3-bit grant can index them directly.
   for (genvar i = 0; i < MaxPorts; i++) begin : g_ext
      if (i < NUM_PORTS) begin : g_used
         assign vld_ext[i]  = target_tvalid[i];
         assign last_ext[i] = target_tlast[i];
         assign data_ext[i] = target_tdata[i*DATA_WIDTH +: DATA_WIDTH];
         assign target_tready[i] = busy && (grant_q == 3'(i)) && up_ready;
      end else begin : g_pad
         assign vld_ext[i]  = 1'b0;
         assign last_ext[i] = 1'b0;
         assign data_ext[i] = '0;
      end
   end

   always_comb begin
      found   = 1'b0;
      grant_d = grant_q;
      idx     = '0;
      for (int unsigned i = 1; i <= MaxPorts; i++) begin
         idx = 3'((32'(last_grant_q) + i) % NUM_PORTS);
         if (!found && (i <= NUM_PORTS) && vld_ext[idx]) begin
            found   = 1'b1;
            grant_d = idx;
         end
      end
   end

   assign busy      = (state_q == StBusy);
   assign g_valid   = vld_ext[grant_q];
   assign g_last    = last_ext[grant_q];
   assign g_data    = data_ext[grant_q];
   assign up_valid  = busy && g_valid;
   assign fire_last = up_valid && up_ready && g_last;

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q      <= StIdle;
         grant_q      <= '0;
         last_grant_q <= 3'(NUM_PORTS - 1);
      end else begin
         unique case (state_q)
            StIdle: begin
               if (found) begin
                  grant_q <= grant_d;
                  state_q <= StBusy;
               end
            end
            StBusy: begin
               if (fire_last) begin
                  last_grant_q <= grant_q;
                  state_q      <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

`ifdef DEST_ARBITER_REG_OUT_EN
   logic                  slv_valid_q, slv_last_q;
   logic [DATA_WIDTH-1:0] slv_data_q;
   logic [2:0]            slv_tid_q;

   // Slice accepts whenever it is empty or draining this cycle.
   assign up_ready = !slv_valid_q || initiator_tready;

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         slv_valid_q <= 1'b0;
         slv_last_q  <= 1'b0;
         slv_data_q  <= '0;
         slv_tid_q   <= '0;
      end else if (up_ready) begin
         slv_valid_q <= up_valid;
         slv_last_q  <= g_last;
         slv_data_q  <= g_data;
         slv_tid_q   <= grant_q;
      end
   end

   assign initiator_tvalid = slv_valid_q;
   assign initiator_tlast  = slv_last_q;
   assign initiator_tdata  = slv_data_q;
   assign initiator_tid    = slv_tid_q;
`else
   assign up_ready         = initiator_tready;
   assign initiator_tvalid = up_valid;
   assign initiator_tlast  = g_last;
   assign initiator_tdata  = g_data;
   assign initiator_tid    = grant_q;
`endif

endmodule

// File: doc/dest_arbiter.md
DEST_ARBITER -- requirements
Module: dest_arbiter

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 4, number of target streams (legal range 1..8).
REQ-002 SHALL have parameter DATA_WIDTH, default 8, tdata width of all streams.
REQ-003 SHALL have port aclk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port aresetn  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port target_tvalid  input  NUM_PORTS  per-port beat valid.
REQ-006 SHALL have port target_tready  output  NUM_PORTS  per-port beat ready.
REQ-007 SHALL have port target_tlast  input  NUM_PORTS  per-port end of packet.
REQ-008 SHALL have port target_tdata  input  NUM_PORTS x DATA_WIDTH  per-port data; port i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-009 SHALL have port initiator_tvalid  output  1  merged beat valid.
REQ-010 SHALL have port initiator_tready  input  1  merged beat ready.
REQ-011 SHALL have port initiator_tlast  output  1  merged end of packet.
REQ-012 SHALL have port initiator_tdata  output  DATA_WIDTH  merged data.
REQ-013 SHALL have port initiator_tid  output  3  index of the source port; feeds dest_insert target_tid.

Function
REQ-014 SHALL merge the target streams into one packet stream, tagging each packet with its source port index on initiator_tid.
REQ-015 SHALL use an FSM with states IDLE and BUSY, plus a grant register and a last_grant register, each 3 bits wide.
REQ-016 In IDLE with any target_tvalid high: SHALL grant the first requesting port found round-robin, searching from last_grant+1 modulo NUM_PORTS; SHALL enter BUSY on the next edge.
REQ-017 In IDLE: all target_tready SHALL be 0 and initiator_tvalid SHALL be 0, giving one bubble cycle per packet.
REQ-018 In BUSY, for granted port g: initiator_tvalid/tlast/tdata SHALL equal target_*[g].
REQ-019 In BUSY: target_tready[g] SHALL equal initiator_tready; all other target_tready SHALL be 0.
REQ-020 In BUSY: initiator_tid SHALL equal g and SHALL stay constant for every beat of the packet.
REQ-021 Grant lock: the grant SHALL NOT change until a beat with tlast=1 transfers (tvalid and tready both high).
REQ-022 On the tlast transfer: SHALL load last_grant with g and return to IDLE on the same edge.
REQ-023 If target_tvalid[g] drops mid-packet: SHALL hold the grant; initiator_tvalid follows it low.
REQ-024 A single-beat packet (tlast on the first beat) SHALL complete in one BUSY cycle.
REQ-025 A port that is the only requester SHALL be re-granted, with one bubble between packets.
REQ-026 Simultaneous requests SHALL be served in strict round-robin order; no port waits more than NUM_PORTS-1 packets.
REQ-027 With initiator_tready held low: SHALL hold tvalid and data stable (AXI4-Stream rule); no target beat is consumed.

Reset
REQ-028 While aresetn=0: state SHALL be IDLE, grant 0, last_grant NUM_PORTS-1 (port 0 wins first), initiator_tvalid 0, all target_tready 0.
REQ-029 Reset asserted mid-packet SHALL abandon the packet; after release, arbitration SHALL restart from REQ-028 values.

Configuration
REQ-030 Macro DEST_ARBITER_REG_OUT_EN defined: SHALL insert a full-throughput output register slice on initiator_tvalid/tlast/tdata/tid.
REQ-031 Register slice behaviour: load when empty or when initiator_tready=1; reset to empty; adds exactly 1 cycle latency; sustains 1 beat/cycle.
REQ-032 Macro DEST_ARBITER_REG_OUT_EN undefined: SHALL drive outputs combinationally from the granted port with 0 added latency.

Verification
REQ-033 Port 2 sends 3 beats 0x11,0x22,0x33 (tlast on 0x33), initiator_tready=1 -> after 1 idle cycle, 3 consecutive beats with tid=2 and tlast on the third.
REQ-034 Ports 0,1,3 request together after reset, 1-beat packets each -> output tid order 0,1,3, then 0 again if port 0 re-requests.
REQ-035 Port 1 mid-packet while port 0 requests; initiator_tready toggles 1,0,1 -> port 1 packet completes intact and unbroken; port 0 packet follows with tid=0.
REQ-036 Port 0 drops tvalid for 2 cycles mid-packet -> grant held, no port 1 data interleaved, initiator_tid stays 0.
REQ-037 aresetn pulsed low during beat 2 of a 4-beat packet -> initiator_tvalid 0 immediately; next packet granted from port 0.
REQ-038 Rerun REQ-033 with DEST_ARBITER_REG_OUT_EN defined -> identical beats, each 1 cycle later.
